// File: rtl/serial_bus_arbiter.sv
// Arbitrates the single touch-panel SCLK pin between the LCD config controller (req0)
// and the touch ADC controller (req1), with a guard gap between owners and a hold watchdog.
module serial_bus_arbiter #(
    parameter int   GUARD_CYCLES   = 4,
    parameter int   TIMEOUT_CYCLES = 65535,
    parameter int   FIXED_PRIO     = 0,
    parameter logic SCLK_IDLE      = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       sclk0,
    output logic       gnt0,
    input  logic       req1,
    input  logic       sclk1,
    output logic       gnt1,
    output logic       sclk_out,
    output logic [1:0] owner,
    output logic       timeout_err,
    output logic [7:0] timeout_count
);
    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, GUARD} state_t;

    localparam logic [7:0]  GUARD_LAST  = 8'(GUARD_CYCLES - 1);
    localparam logic [16:0] TIMEOUT_LIM = 17'(TIMEOUT_CYCLES);
    localparam logic        WD_EN       = (TIMEOUT_CYCLES != 0);
    localparam logic        FIXED       = (FIXED_PRIO != 0);

    state_t      state_q, state_d;
    logic [1:0]  owner_q, owner_d;
    logic [15:0] hold_q, hold_d;
    logic [7:0]  guard_q, guard_d;
    logic        last_owner_q, last_owner_d;
    logic        blocked0_q, blocked0_d;
    logic        blocked1_q, blocked1_d;
    logic        timeout_err_q, timeout_err_d;
    logic [7:0]  timeout_count_q, timeout_count_d;

    logic elig0, elig1, pick1, arbitrate, revoke, held_req;

    // last_owner_q: 0 = requester 0 held the bus last, 1 = requester 1
    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        hold_d          = hold_q;
        guard_d         = guard_q;
        last_owner_d    = last_owner_q;
        blocked0_d      = blocked0_q & req0;
        blocked1_d      = blocked1_q & req1;
        timeout_err_d   = 1'b0;
        timeout_count_d = timeout_count_q;
        arbitrate       = 1'b0;
        revoke          = 1'b0;
        held_req        = 1'b0;

        elig0 = req0 & ~blocked0_q;
        elig1 = req1 & ~blocked1_q;
        pick1 = elig1 & (~elig0 | (~FIXED & ~last_owner_q));

        case (state_q)
            IDLE: arbitrate = 1'b1;
            GRANT0, GRANT1: begin
                hold_d   = hold_q + 16'd1;
                held_req = (state_q == GRANT0) ? req0 : req1;
                if (!held_req) begin
                    state_d = GUARD;
                end else if (WD_EN && (({1'b0, hold_q} + 17'd1) == TIMEOUT_LIM)) begin
                    state_d = GUARD;
                    revoke  = 1'b1;
                end
            end
            GUARD: begin
                if (guard_q == GUARD_LAST) begin
                    guard_d   = '0;
                    state_d   = IDLE;
                    arbitrate = 1'b1;
                end else begin
                    guard_d = guard_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d == GUARD && state_q != GUARD) begin
            owner_d = 2'b00;
            hold_d  = '0;
            guard_d = '0;
        end

        if (revoke) begin
            timeout_err_d = 1'b1;
            if (timeout_count_q != 8'hFF) begin
                timeout_count_d = timeout_count_q + 8'd1;
            end
            if (state_q == GRANT0) begin
                blocked0_d = 1'b1;
            end else begin
                blocked1_d = 1'b1;
            end
        end

        // Release always passes through GUARD, so arbitration only happens in IDLE or at guard end
        if (arbitrate && (elig0 | elig1)) begin
            state_d      = pick1 ? GRANT1 : GRANT0;
            owner_d      = pick1 ? 2'b10 : 2'b01;
            last_owner_d = pick1;
            hold_d       = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            owner_q         <= 2'b00;
            hold_q          <= '0;
            guard_q         <= '0;
            last_owner_q    <= 1'b1;
            blocked0_q      <= 1'b0;
            blocked1_q      <= 1'b0;
            timeout_err_q   <= 1'b0;
            timeout_count_q <= '0;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            hold_q          <= hold_d;
            guard_q         <= guard_d;
            last_owner_q    <= last_owner_d;
            blocked0_q      <= blocked0_d;
            blocked1_q      <= blocked1_d;
            timeout_err_q   <= timeout_err_d;
            timeout_count_q <= timeout_count_d;
        end
    end

    // Decoded from the owner flops only, so the pin mux cannot glitch on a state change
    always_comb begin
        case (owner_q)
            2'b01:   sclk_out = sclk0;
            2'b10:   sclk_out = sclk1;
            default: sclk_out = SCLK_IDLE;
        endcase
    end

    assign gnt0          = (owner_q == 2'b01);
    assign gnt1          = (owner_q == 2'b10);
    assign owner         = owner_q;
    assign timeout_err   = timeout_err_q;
    assign timeout_count = timeout_count_q;
endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Bench for serial_bus_arbiter: four differently configured instances share one set of
// requester inputs; directed scenarios plus a randomized run against a behavioural model.
module tb_serial_bus_arbiter;
    logic clk, rst, req0, req1, sclk0, sclk1;
    logic [3:0] gnt0_o, gnt1_o, sclk_o, terr_o;
    logic [1:0] owner_o [4];
    logic [7:0] tcnt_o [4];
    int n_tests = 0;
    int n_fail  = 0;

    function automatic int guard_of(int i);
        return (i == 3) ? 1 : 4;
    endfunction
    function automatic int timeout_of(int i);
        return (i == 2) ? 20 : (i == 3) ? 3 : 65535;
    endfunction
    function automatic int fixed_of(int i);
        return (i == 1) ? 1 : 0;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_dut
        serial_bus_arbiter #(
            .GUARD_CYCLES  (guard_of(g)),
            .TIMEOUT_CYCLES(timeout_of(g)),
            .FIXED_PRIO    (fixed_of(g)),
            .SCLK_IDLE     (1'b0)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .req0         (req0),
            .sclk0        (sclk0),
            .gnt0         (gnt0_o[g]),
            .req1         (req1),
            .sclk1        (sclk1),
            .gnt1         (gnt1_o[g]),
            .sclk_out     (sclk_o[g]),
            .owner        (owner_o[g]),
            .timeout_err  (terr_o[g]),
            .timeout_count(tcnt_o[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: owner 0 = none, 1 = requester 0, 2 = requester 1
    typedef struct {
        int owner;
        int guard_left;
        int held;
        int last;
        bit blk0;
        bit blk1;
        int tcnt;
        bit terr;
    } mdl_t;

    mdl_t m [4];

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.owner = 0; r.guard_left = 0; r.held = 0; r.last = 2;
        r.blk0 = 0; r.blk1 = 0; r.tcnt = 0; r.terr = 0;
        return r;
    endfunction

    function automatic mdl_t mdl_next(mdl_t c, bit r0, bit r1, int i);
        mdl_t n;
        bit e0, e1, arb, still;
        int w;
        n = c;
        n.terr = 0;
        arb = 0;
        e0 = r0 && !c.blk0;
        e1 = r1 && !c.blk1;
        if (!r0) n.blk0 = 0;
        if (!r1) n.blk1 = 0;
        if (c.owner != 0) begin
            still = (c.owner == 1) ? r0 : r1;
            n.held = c.held + 1;
            if (!still) begin
                n.owner = 0;
                n.guard_left = guard_of(i);
            end else if (timeout_of(i) != 0 && n.held == timeout_of(i)) begin
                n.owner = 0;
                n.guard_left = guard_of(i);
                n.terr = 1;
                n.tcnt = (c.tcnt < 255) ? c.tcnt + 1 : 255;
                if (c.owner == 1) n.blk0 = 1;
                else n.blk1 = 1;
            end
        end else if (c.guard_left > 0) begin
            n.guard_left = c.guard_left - 1;
            arb = (n.guard_left == 0);
        end else begin
            arb = 1;
        end
        if (arb && (e0 || e1)) begin
            if (e0 && e1) w = (fixed_of(i) != 0) ? 1 : ((c.last == 1) ? 2 : 1);
            else w = e0 ? 1 : 2;
            n.owner = w;
            n.last = w;
            n.held = 0;
        end
        return n;
    endfunction

    function automatic logic [13:0] mdl_out(mdl_t c, logic s0, logic s1);
        logic [1:0] eown;
        logic esclk;
        eown  = (c.owner == 1) ? 2'b01 : (c.owner == 2) ? 2'b10 : 2'b00;
        esclk = (c.owner == 1) ? s0 : (c.owner == 2) ? s1 : 1'b0;
        return {c.owner == 1, c.owner == 2, eown, esclk, c.terr, 8'(c.tcnt)};
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 4; i++) begin
            if (rst) m[i] <= mdl_reset();
            else m[i] <= mdl_next(m[i], req0, req1, i);
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; sclk0 = 1'b0; sclk1 = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; sclk0 = 1'b1; sclk1 = 1'b1;
        cyc();
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if ({gnt0_o[i], gnt1_o[i], owner_o[i], sclk_o[i], terr_o[i], tcnt_o[i]} !== 14'd0) begin
                n_fail++;
                $display("[TB] FAIL reset_state dut%0d: gnt0=%b gnt1=%b owner=%b sclk_out=%b terr=%b count=%0d, expected all 0",
                         i, gnt0_o[i], gnt1_o[i], owner_o[i], sclk_o[i], terr_o[i], tcnt_o[i]);
            end
        end
        sclk0 = 1'b0; sclk1 = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_first_grant();
        apply_reset();
        for (int k = 0; k < 5; k++) cyc();
        req0 = 1'b1;
        n_tests++;
        if (owner_o[0] !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL fg_before_grant: owner=%b, expected 00", owner_o[0]);
        end
        cyc();
        n_tests++;
        if (gnt0_o[0] !== 1'b1 || owner_o[0] !== 2'b01 || gnt1_o[0] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL fg_grant: gnt0=%b owner=%b gnt1=%b, expected 1 01 0", gnt0_o[0], owner_o[0], gnt1_o[0]);
        end
        req1 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            sclk0 = ~sclk0;
            #1;
            n_tests++;
            if (sclk_o[0] !== sclk0 || gnt1_o[0] !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL fg_sclk_follow: sclk_out=%b gnt1=%b, expected %b 0", sclk_o[0], gnt1_o[0], sclk0);
            end
            cyc();
        end
        req0 = 1'b0; req1 = 1'b0; sclk0 = 1'b0;
        cyc();
        n_tests++;
        if (owner_o[0] !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL fg_release: owner=%b, expected 00", owner_o[0]);
        end
    endtask

    task automatic test_round_robin();
        int idle_cnt;
        bit granted;
        apply_reset();
        req0 = 1'b1; req1 = 1'b1;
        cyc();
        n_tests++;
        if (gnt0_o[0] !== 1'b1 || gnt1_o[0] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL rr_first_tie: gnt0=%b gnt1=%b, expected 1 0", gnt0_o[0], gnt1_o[0]);
        end
        for (int k = 1; k < 10; k++) cyc();
        req0 = 1'b0; sclk0 = 1'b1; sclk1 = 1'b1;
        idle_cnt = 0;
        granted = 0;
        for (int k = 0; k < 20 && !granted; k++) begin
            cyc();
            if (owner_o[0] === 2'b10) granted = 1;
            else if (owner_o[0] === 2'b00 && sclk_o[0] === 1'b0) idle_cnt++;
        end
        n_tests++;
        if (!granted || idle_cnt != 4 || sclk_o[0] !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL rr_guard_then_gnt1: granted=%0d idle_cycles=%0d sclk_out=%b, expected 1 4 1",
                     granted, idle_cnt, sclk_o[0]);
        end
        for (int k = 1; k < 10; k++) cyc();
        req1 = 1'b0; sclk0 = 1'b0; sclk1 = 1'b0;
        for (int k = 0; k < 8; k++) cyc();
        req0 = 1'b1; req1 = 1'b1;
        cyc();
        n_tests++;
        if (gnt0_o[0] !== 1'b1 || gnt1_o[0] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL rr_second_tie: gnt0=%b gnt1=%b, expected 1 0", gnt0_o[0], gnt1_o[0]);
        end
        cyc();
        req0 = 1'b0; req1 = 1'b0;
        for (int k = 0; k < 8; k++) cyc();
        req0 = 1'b1; req1 = 1'b1;
        cyc();
        n_tests++;
        if (gnt1_o[0] !== 1'b1 || gnt0_o[0] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL rr_third_tie: gnt0=%b gnt1=%b, expected 0 1", gnt0_o[0], gnt1_o[0]);
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_fixed_prio();
        int w;
        apply_reset();
        req0 = 1'b1; req1 = 1'b1;
        for (int r = 0; r < 4; r++) begin
            w = 0;
            do begin cyc(); w++; end while (owner_o[1] === 2'b00 && w < 12);
            n_tests++;
            if (owner_o[1] !== 2'b01) begin
                n_fail++;
                $display("[TB] FAIL fp_tie_round%0d: owner=%b, expected 01", r, owner_o[1]);
            end
            for (int k = 0; k < 3; k++) cyc();
            req0 = 1'b0;
            cyc();
            req0 = (r != 3);
        end
        w = 0;
        do begin cyc(); w++; end while (owner_o[1] === 2'b00 && w < 12);
        n_tests++;
        if (owner_o[1] !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL fp_req1_when_req0_low: owner=%b, expected 10", owner_o[1]);
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_timeout();
        int granted, pulses, total, k, w;
        bit dropped, regrant;
        apply_reset();
        req1 = 1'b1;
        granted = 0; pulses = 0; dropped = 0; regrant = 0;
        for (int c = 0; c < 100; c++) begin
            cyc();
            if (gnt1_o[2] === 1'b1) begin
                granted++;
                if (dropped) regrant = 1;
            end else if (granted > 0) begin
                dropped = 1;
            end
            if (terr_o[2] === 1'b1) pulses++;
        end
        n_tests++;
        if (granted != 20 || pulses != 1 || tcnt_o[2] !== 8'd1 || regrant) begin
            n_fail++;
            $display("[TB] FAIL to_first_revoke: granted=%0d pulses=%0d count=%0d regrant=%0d, expected 20 1 1 0",
                     granted, pulses, tcnt_o[2], regrant);
        end
        req1 = 1'b0;
        cyc();
        req1 = 1'b1;
        w = 0;
        do begin cyc(); w++; end while (gnt1_o[2] !== 1'b1 && w < 10);
        n_tests++;
        if (gnt1_o[2] !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL to_regrant_after_drop: gnt1=%b, expected 1", gnt1_o[2]);
        end
        total = 1;
        k = 0;
        while (total < 260 && k < 20000) begin
            cyc();
            k++;
            if (terr_o[2] === 1'b1) begin
                total++;
                req1 = 1'b0;
                if (total == 200) begin
                    n_tests++;
                    if (tcnt_o[2] !== 8'd200) begin
                        n_fail++;
                        $display("[TB] FAIL to_count_200: count=%0d, expected 200", tcnt_o[2]);
                    end
                end
            end else begin
                req1 = 1'b1;
            end
        end
        n_tests++;
        if (total < 260 || tcnt_o[2] !== 8'd255) begin
            n_fail++;
            $display("[TB] FAIL to_count_saturate: revokes=%0d count=%0d, expected 260 255", total, tcnt_o[2]);
        end
        req1 = 1'b0;
    endtask

    task automatic test_reset_midway();
        apply_reset();
        req1 = 1'b1;
        cyc();
        n_tests++;
        if (owner_o[0] !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL rm_granted: owner=%b, expected 10", owner_o[0]);
        end
        for (int k = 0; k < 4; k++) begin
            sclk1 = ~sclk1;
            #1;
            n_tests++;
            if (sclk_o[0] !== sclk1) begin
                n_fail++;
                $display("[TB] FAIL rm_sclk_follow: sclk_out=%b, expected %b", sclk_o[0], sclk1);
            end
            cyc();
        end
        sclk1 = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (gnt1_o[0] !== 1'b0 || owner_o[0] !== 2'b00 || sclk_o[0] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL rm_async_drop: gnt1=%b owner=%b sclk_out=%b, expected 0 00 0",
                     gnt1_o[0], owner_o[0], sclk_o[0]);
        end
        cyc();
        rst = 1'b0; req0 = 1'b1; req1 = 1'b1; sclk1 = 1'b0;
        cyc();
        n_tests++;
        if (gnt0_o[0] !== 1'b1 || gnt1_o[0] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL rm_tie_after_reset: gnt0=%b gnt1=%b, expected 1 0", gnt0_o[0], gnt1_o[0]);
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_guard_pulse();
        int bad;
        apply_reset();
        req0 = 1'b1;
        cyc();
        cyc();
        req0 = 1'b0;
        cyc();
        cyc();
        req0 = 1'b1;
        cyc();
        req0 = 1'b0;
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            if (owner_o[0] !== 2'b00) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("[TB] FAIL gp_no_grant: cycles_with_owner=%0d, expected 0", bad);
        end
        req1 = 1'b1;
        cyc();
        n_tests++;
        if (gnt1_o[0] !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL gp_idle_after_guard: gnt1=%b, expected 1", gnt1_o[0]);
        end
        req1 = 1'b0;
    endtask

    task automatic test_random();
        logic [13:0] act, exp;
        int p;
        apply_reset();
        for (int k = 0; k < 4000; k++) begin
            cyc();
            for (int i = 0; i < 4; i++) begin
                act = {gnt0_o[i], gnt1_o[i], owner_o[i], sclk_o[i], terr_o[i], tcnt_o[i]};
                exp = mdl_out(m[i], sclk0, sclk1);
                n_tests++;
                if (act !== exp) begin
                    n_fail++;
                    $display("[TB] FAIL random dut%0d cycle %0d: {gnt0,gnt1,owner,sclk,terr,count}=%b, expected %b",
                             i, k, act, exp);
                end
            end
            p = (k < 2000) ? 7 : 39;
            if ($urandom_range(p, 0) == 0) req0 = ~req0;
            if ($urandom_range(p, 0) == 0) req1 = ~req1;
            sclk0 = 1'($urandom);
            sclk1 = 1'($urandom);
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; sclk0 = 1'b0; sclk1 = 1'b0;
        test_reset();
        test_first_grant();
        test_round_robin();
        test_fixed_prio();
        test_timeout();
        test_reset_midway();
        test_guard_pulse();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
